// File: rtl/multicycle_ctrl_ext.sv
// Control FSM for the MIPS-32 multi-cycle datapath with I-type ALU ops, bne, jal,
// MemReady wait states, a bounded memory-stall timeout and an exception trap.
module multicycle_ctrl_ext #(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          ENABLE_EXT = 1'b1
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] Cause,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_LW = 4'd3,
    WB_LW    = 4'd4,  MEM_SW = 4'd5,  EXEC_R   = 4'd6,  WB_R   = 4'd7,
    BRANCH   = 4'd8,  JUMP   = 4'd9,  EXEC_I   = 4'd10, WB_I   = 4'd11,
    JAL      = 4'd12, TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int unsigned   CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [1:0]    cause_q, cause_next;
  logic          waiting, timed_out;

  function automatic state_t decode_op(input logic [5:0] op);
    state_t s;
    case (op)
      OP_LW, OP_SW:                      s = MEM_ADDR;
      OP_RTYPE:                          s = EXEC_R;
      OP_J:                              s = JUMP;
      OP_BEQ:                            s = BRANCH;
      OP_BNE:                            s = ENABLE_EXT ? BRANCH : TRAP;
      OP_JAL:                            s = ENABLE_EXT ? JAL : TRAP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: s = ENABLE_EXT ? EXEC_I : TRAP;
      default:                           s = TRAP;
    endcase
    return s;
  endfunction

  // A memory access is stalling when a memory state sees MemReady low.
  assign waiting   = (state == FETCH || state == MEM_LW || state == MEM_SW) && !MemReady;
  assign timed_out = (TIMEOUT != 0) && waiting && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state   <= FETCH;
      count   <= '0;
      cause_q <= 2'b00;
    end else begin
      state <= state_next;
      if (waiting && TIMEOUT != 0) count <= count + CW'(1);
      else                         count <= '0;
      if (state_next == TRAP) cause_q <= cause_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_next    = state;
    cause_next    = 2'b00;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ALUSrcA       = 1'b0;
    RegWrite      = 1'b0;
    EPCWrite      = 1'b0;
    CauseWrite    = 1'b0;
    PCSource      = 2'b00;
    ALUOp         = 2'b00;
    ALUSrcB       = 2'b00;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;

    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        // Completion is checked first so it wins over a same-cycle timeout.
        if (MemReady)       state_next = DECODE;
        else if (timed_out) begin
          state_next = TRAP;
          cause_next = 2'b01;
        end
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        state_next = decode_op(Opcode);
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_LW) ? MEM_LW : MEM_SW;
      end
      MEM_LW: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)       state_next = WB_LW;
        else if (timed_out) begin
          state_next = TRAP;
          cause_next = 2'b10;
        end
      end
      WB_LW: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        state_next = FETCH;
      end
      MEM_SW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady)       state_next = FETCH;
        else if (timed_out) begin
          state_next = TRAP;
          cause_next = 2'b10;
        end
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = WB_R;
      end
      WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCSource      = 2'b01;
        PCWriteCond   = (Opcode == OP_BEQ);
        PCWriteCondNE = (Opcode == OP_BNE);
        state_next    = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        state_next = FETCH;
      end
      EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = 2'b11;
        state_next = WB_I;
      end
      WB_I: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        // r31 captures the current PC (already PC+4) on the same edge the PC jumps.
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        state_next = FETCH;
      end
      TRAP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b11;
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Reset suppresses every write strobe; mux selects still follow the state.
    if (Reset) begin
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      PCWriteCondNE = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      EPCWrite      = 1'b0;
      CauseWrite    = 1'b0;
    end
  end

  assign Cause = cause_q;
  assign State = state;

endmodule
